// File: rtl/tmr_recovery_pkg.sv
// Shared types and default timing constants for the TMR recovery controller.
package tmr_recovery_pkg;

    localparam int unsigned DEFAULT_RST_CYCLES = 8;
    localparam int unsigned DEFAULT_TIMEOUT    = 1024;
    localparam int unsigned ERR_CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_RESET,
        ST_BOOT,
        ST_SYNC,
        ST_DONE,
        ST_FAIL
    } state_e;

endpackage

// File: rtl/tmr_rec_timer.sv
// Loadable down-counter; expired is high on the last cycle of a loaded interval.
module tmr_rec_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Holds at zero once run out so an idle timer never re-fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovers a single faulty hart of a lockstep TMR group: halt healthy harts,
// reset the faulty one, reboot and resynchronise all harts via interrupt.
module tmr_recovery_ctrl
    import tmr_recovery_pkg::*;
#(
    parameter int unsigned NHARTS     = 3,
    parameter int unsigned RST_CYCLES = DEFAULT_RST_CYCLES,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 tmr_error_i,
    input  logic [NHARTS-1:0]    voter_id_error_i,
    input  logic [NHARTS-1:0]    halt_ack_i,
    input  logic [NHARTS-1:0]    hart_wfi_i,
    input  logic [NHARTS-1:0]    hart_intc_ack_i,
    output logic [NHARTS-1:0]    halt_req_o,
    output logic [NHARTS-1:0]    core_rst_no,
    output logic [NHARTS-1:0]    boot_sel_o,
    output logic [NHARTS-1:0]    intr_sync_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int unsigned MAX_CYC = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e                 state_q, state_d;
    logic [NHARTS-1:0]      f_q, f_d;
    logic [NHARTS-1:0]      ack_q, ack_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic                   err_inc;
    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_val;
    logic                   tmr_expired;

    tmr_rec_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next state; the timer is reloaded on every entry into a timed state.
    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        ack_d    = ack_q;
        err_inc  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(TIMEOUT);
        case (state_q)
            ST_IDLE: begin
                if (enable_i && tmr_error_i) begin
                    if ($onehot(voter_id_error_i)) begin
                        state_d  = ST_HALT;
                        f_d      = voter_id_error_i;
                        err_inc  = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_HALT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    f_d     = '0;
                end else if ((halt_ack_i & ~f_q) == ~f_q) begin
                    state_d  = ST_RESET;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(RST_CYCLES);
                end else if (tmr_expired) begin
                    state_d = ST_FAIL;
                    f_d     = '0;
                end
            end
            ST_RESET: begin
                if (tmr_expired) begin
                    state_d  = ST_BOOT;
                    tmr_load = 1'b1;
                end
            end
            ST_BOOT: begin
                if (&hart_wfi_i) begin
                    state_d  = ST_SYNC;
                    ack_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_FAIL;
                    f_d     = '0;
                end
            end
            ST_SYNC: begin
                ack_d = ack_q | hart_intc_ack_i;
                if (&ack_d) begin
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    state_d = ST_FAIL;
                    f_d     = '0;
                    ack_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                f_d     = '0;
                ack_d   = '0;
            end
            ST_FAIL: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                f_d     = '0;
                ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            f_q       <= '0;
            ack_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            ack_q   <= ack_d;
            if (err_inc && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Outputs decode only registered state, so reset releases them immediately.
    always_comb begin
        halt_req_o  = '0;
        core_rst_no = '1;
        boot_sel_o  = '0;
        intr_sync_o = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        fail_o      = 1'b0;
        case (state_q)
            ST_HALT: begin
                halt_req_o = ~f_q;
                busy_o     = 1'b1;
            end
            ST_RESET: begin
                halt_req_o  = ~f_q;
                core_rst_no = ~f_q;
                boot_sel_o  = f_q;
                busy_o      = 1'b1;
            end
            ST_BOOT: begin
                boot_sel_o = f_q;
                busy_o     = 1'b1;
            end
            ST_SYNC: begin
                intr_sync_o = ~ack_q;
                busy_o      = 1'b1;
            end
            ST_DONE: done_o = 1'b1;
            ST_FAIL: fail_o = 1'b1;
            default: ;
        endcase
    end

    assign err_count_o = err_cnt_q;

endmodule

// File: doc/tmr_recovery_ctrl.md
TMR_RECOVERY_CTRL -- requirements
Module: tmr_recovery_ctrl

Interface
REQ-001 SHALL have parameter NHARTS, default 3, number of lockstep harts.
REQ-002 SHALL have parameter RST_CYCLES, default 8, faulty-hart reset pulse length in cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles waited in any wait state.
REQ-004 SHALL have port clk_i, input, 1, sole clock.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable_i, input, 1, TMR sync mode active.
REQ-007 SHALL have port tmr_error_i, input, 1, voter mismatch flag.
REQ-008 SHALL have port voter_id_error_i, input, NHARTS, per-hart disagreement mask.
REQ-009 SHALL have port halt_ack_i, input, NHARTS, per-hart halted.
REQ-010 SHALL have port hart_wfi_i, input, NHARTS, per-hart in WFI.
REQ-011 SHALL have port hart_intc_ack_i, input, NHARTS, per-hart sync-interrupt taken.
REQ-012 SHALL have port halt_req_o, output, NHARTS, halt request.
REQ-013 SHALL have port core_rst_no, output, NHARTS, active-low per-hart core reset.
REQ-014 SHALL have port boot_sel_o, output, NHARTS, 1 = recovery boot address.
REQ-015 SHALL have port intr_sync_o, output, NHARTS, sync interrupt.
REQ-016 SHALL have port busy_o, output, 1, recovery in progress.
REQ-017 SHALL have port done_o, output, 1, one-cycle recovery-complete pulse.
REQ-018 SHALL have port fail_o, output, 1, unrecoverable error, sticky.
REQ-019 SHALL have port err_count_o, output, 8, recoveries started, saturating.

Function
REQ-020 SHALL implement states IDLE, HALT, RESET, BOOT, SYNC, DONE, FAIL.
REQ-021 IDLE: when enable_i=1 and tmr_error_i=1 and voter_id_error_i is one-hot, SHALL latch it as faulty mask F and go to HALT.
REQ-022 IDLE: when enable_i=1 and tmr_error_i=1 and voter_id_error_i is zero or multi-hot, SHALL go to FAIL.
REQ-023 SHALL increment err_count_o on every IDLE->HALT transition, saturating at 255.
REQ-024 HALT: halt_req_o=~F; go to RESET when (halt_ack_i & ~F) == ~F.
REQ-025 HALT: when enable_i=0, SHALL abort to IDLE with all outputs at reset values.
REQ-026 RESET: core_rst_no=~F and boot_sel_o=F for exactly RST_CYCLES cycles, then go to BOOT; halt_req_o=~F held.
REQ-027 BOOT: halt_req_o=0, boot_sel_o=F; go to SYNC when hart_wfi_i is all ones.
REQ-028 SYNC: intr_sync_o all ones per hart until that hart's hart_intc_ack_i is seen (sticky ack mask, then that bit drops); go to DONE when the ack mask is all ones.
REQ-029 DONE: done_o=1 for one cycle, then go to IDLE, clearing F and the ack mask.
REQ-030 HALT, BOOT and SYNC SHALL share a wait counter cleared on state entry; reaching TIMEOUT cycles in any of them SHALL go to FAIL.
REQ-031 FAIL: fail_o=1 and all other per-hart outputs at reset values; return to IDLE only when enable_i=0.
REQ-032 From RESET, BOOT and SYNC, enable_i=0 and tmr_error_i SHALL be ignored until DONE or FAIL.
REQ-033 busy_o=1 in HALT, RESET, BOOT and SYNC; 0 otherwise.
REQ-034 All outputs SHALL be registered-state decodes with no combinational path from inputs.

Reset
REQ-035 rst_i=1 SHALL asynchronously force IDLE, F=0, ack mask=0, counters=0.
REQ-036 Reset output values: halt_req_o=0, core_rst_no=all ones, boot_sel_o=0, intr_sync_o=0, busy_o=0, done_o=0, fail_o=0, err_count_o=0.
REQ-037 Reset mid-recovery SHALL release core_rst_no and halt_req_o in the same cycle.

Structure
REQ-038 SHALL place the state enum and default RST_CYCLES/TIMEOUT constants in a shared package (tmr_recovery_pkg).
REQ-039 SHALL use one sub-module, tmr_rec_timer: a loadable down-counter with expiry flag, shared by RESET length and timeout.

Verification
REQ-040 voter_id_error_i=3'b010 with tmr_error_i -> halt_req_o=3'b101; acks 3'b101 -> core_rst_no=3'b101 for 8 cycles; wfi=3'b111 -> intr_sync_o=3'b111; acks -> done_o pulse; err_count_o=1.
REQ-041 voter_id_error_i=3'b011 -> FAIL, fail_o=1, core_rst_no=3'b111; enable_i=0 -> IDLE.
REQ-042 Halt ack withheld -> fail_o rises exactly 1024 cycles after HALT entry.
REQ-043 Staggered intc acks (hart0, then hart2, then hart1) -> each intr_sync_o bit drops after its ack; done_o only after the third ack.
REQ-044 rst_i asserted during RESET -> next edge shows core_rst_no=3'b111, busy_o=0, IDLE.
REQ-045 256 consecutive recoveries -> err_count_o holds at 255.
